// File: rtl/fcnt_pkg.sv
// fcnt_pkg: shared types for the dual-channel VCO frequency counter.
// Holds the measurement FSM states and the rd_sel byte-select codes.
package fcnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        GATE  = 2'd2,
        LATCH = 2'd3
    } fcnt_state_e;

    localparam logic [1:0] SEL_A_LO = 2'd0;
    localparam logic [1:0] SEL_A_HI = 2'd1;
    localparam logic [1:0] SEL_B_LO = 2'd2;
    localparam logic [1:0] SEL_B_HI = 2'd3;

endpackage

// File: rtl/fcnt_channel.sv
// fcnt_channel: one oscillator input -- synchroniser, rising-edge
// detect and a saturating edge counter with sticky overflow.
module fcnt_channel #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc,
    input  logic             clear,
    input  logic             count_en,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("fcnt_channel: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

    // An edge arriving on a full counter is lost, which is what ovf records.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (count_en && edge_det) begin
            if (&count) begin
                ovf <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vco_freq_counter.sv
// vco_freq_counter: gated dual-channel edge counter for the ring-VCO pair.
// Define FCNT_CONTINUOUS_EN to chain windows back-to-back while start is held.
module vco_freq_counter
    import fcnt_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              osc_a,
    input  logic              osc_b,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count_a,
    output logic [CNT_W-1:0]  count_b,
    output logic              ovf_a,
    output logic              ovf_b,
    input  logic [1:0]        rd_sel,
    output logic [7:0]        rd_byte
);

    localparam logic [GATE_W-1:0] TIMER_ONE = GATE_W'(1);
    localparam int RW = (CNT_W < 16) ? CNT_W : 16;

    fcnt_state_e       state_q;
    fcnt_state_e       state_d;
    logic [GATE_W-1:0] timer_q;
    logic              load;
    logic              count_en;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic              ovf_int_a;
    logic              ovf_int_b;
    logic [15:0]       view_a;
    logic [15:0]       view_b;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: state_d = GATE;
            GATE: begin
                if (timer_q == TIMER_ONE) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
`ifdef FCNT_CONTINUOUS_EN
                if (start) begin
                    load    = 1'b1;
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign count_en = (state_q == GATE);
    assign busy     = (state_q != IDLE);

    // A zero gate length still yields a one-cycle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                timer_q <= (gate_len == '0) ? TIMER_ONE : gate_len;
            end else if (count_en) begin
                timer_q <= timer_q - TIMER_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            count_a <= '0;
            count_b <= '0;
            ovf_a   <= 1'b0;
            ovf_b   <= 1'b0;
        end else begin
            done <= (state_q == LATCH);
            if (state_q == LATCH) begin
                count_a <= cnt_a;
                count_b <= cnt_b;
                ovf_a   <= ovf_int_a;
                ovf_b   <= ovf_int_b;
            end
        end
    end

    fcnt_channel #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ch_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .osc      (osc_a),
        .clear    (load),
        .count_en (count_en),
        .count    (cnt_a),
        .ovf      (ovf_int_a)
    );

    fcnt_channel #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ch_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .osc      (osc_b),
        .clear    (load),
        .count_en (count_en),
        .count    (cnt_b),
        .ovf      (ovf_int_b)
    );

    // Narrow counters zero-fill the upper byte; wide ones expose bits 15:0.
    always_comb begin
        view_a = '0;
        view_b = '0;
        view_a[RW-1:0] = count_a[RW-1:0];
        view_b[RW-1:0] = count_b[RW-1:0];
        rd_byte = '0;
        unique case (rd_sel)
            SEL_A_LO: rd_byte = view_a[7:0];
            SEL_A_HI: rd_byte = view_a[15:8];
            SEL_B_LO: rd_byte = view_b[7:0];
            SEL_B_HI: rd_byte = view_b[15:8];
            default:  rd_byte = '0;
        endcase
    end

endmodule

// File: tb/tb_vco_freq_counter.sv
// tb_vco_freq_counter: randomized scoreboard bench, 16-bit and 8-bit builds
// driven in parallel against a window-sum reference model.
module tb_vco_freq_counter;

    localparam int GATE_W = 16;
    localparam int SS     = 2;
    localparam int MAXC   = 65536;
    localparam int RING   = 64;
`ifdef FCNT_CONTINUOUS_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 3;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [GATE_W-1:0] gate_len;
    logic              osc_a;
    logic              osc_b;
    logic [1:0]        rd_sel;

    logic        busy, done, ovf_a, ovf_b;
    logic [15:0] count_a, count_b;
    logic [7:0]  rd_byte;
    logic        busy_s, done_s, ovf_a_s, ovf_b_s;
    logic [7:0]  count_a_s, count_b_s;
    logic [7:0]  rd_byte_s;

    always #5 clk = ~clk;

    vco_freq_counter #(.CNT_W(16), .GATE_W(GATE_W), .SYNC_STAGES(SS)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_len(gate_len),
        .osc_a(osc_a), .osc_b(osc_b), .busy(busy), .done(done),
        .count_a(count_a), .count_b(count_b), .ovf_a(ovf_a), .ovf_b(ovf_b),
        .rd_sel(rd_sel), .rd_byte(rd_byte)
    );

    vco_freq_counter #(.CNT_W(8), .GATE_W(GATE_W), .SYNC_STAGES(SS)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_len(gate_len),
        .osc_a(osc_a), .osc_b(osc_b), .busy(busy_s), .done(done_s),
        .count_a(count_a_s), .count_b(count_b_s), .ovf_a(ovf_a_s),
        .ovf_b(ovf_b_s), .rd_sel(rd_sel), .rd_byte(rd_byte_s)
    );

    // Reference model: oscillator samples, accepted windows, expected results.
    int cyc = 0;
    bit rise_a [MAXC];
    bit rise_b [MAXC];
    bit last_a = 1'b0;
    bit last_b = 1'b0;
    bit have_win = 1'b0;
    int cur_t = 0;
    int cur_n = 0;
    int free_from = 0;
    int win_t [RING];
    int win_n [RING];
    int wr = 0;
    int mn;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_a = 1'b0;
            last_b = 1'b0;
            have_win = 1'b0;
            free_from = 0;
        end else begin
            cyc = cyc + 1;
            if (cyc < MAXC) begin
                rise_a[cyc] = osc_a && !last_a;
                rise_b[cyc] = osc_b && !last_b;
            end
            last_a = osc_a;
            last_b = osc_b;
            if (start && cyc >= free_from) begin
                mn = (gate_len == '0) ? 1 : int'(gate_len);
                cur_t = cyc;
                cur_n = mn;
                have_win = 1'b1;
                free_from = cyc + mn + GAP;
                win_t[wr % RING] = cyc;
                win_n[wr % RING] = mn;
                wr = wr + 1;
            end
        end
    end

    // Scoreboard monitor
    int n_chk = 0;
    int n_pass = 0;
    int rd = 0;
    int la16 = 0, lb16 = 0, la8 = 0, lb8 = 0;
    bit oa16 = 0, ob16 = 0, oa8 = 0, ob8 = 0;
    bit exp_done, exp_busy;
    int sa, sb, e16, e8;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk = n_chk + 1;
        if (act == exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            rd = wr;
            la16 = 0; lb16 = 0; la8 = 0; lb8 = 0;
            oa16 = 0; ob16 = 0; oa8 = 0; ob8 = 0;
        end
        exp_done = (rd != wr) &&
                   (win_t[rd % RING] + win_n[rd % RING] + 2 == cyc);
        exp_busy = have_win && (cyc <= cur_t + cur_n + 1);
        if (exp_done) begin
            sa = 0;
            sb = 0;
            for (int k = win_t[rd % RING] + 2 - SS;
                 k <= win_t[rd % RING] + win_n[rd % RING] + 1 - SS; k++) begin
                sa = sa + int'(rise_a[k]);
                sb = sb + int'(rise_b[k]);
            end
            la16 = (sa > 65535) ? 65535 : sa;
            lb16 = (sb > 65535) ? 65535 : sb;
            oa16 = (sa > 65535);
            ob16 = (sb > 65535);
            la8 = (sa > 255) ? 255 : sa;
            lb8 = (sb > 255) ? 255 : sb;
            oa8 = (sa > 255);
            ob8 = (sb > 255);
            rd = rd + 1;
        end
        case (rd_sel)
            2'd0: begin e16 = la16 & 255;        e8 = la8; end
            2'd1: begin e16 = (la16 >> 8) & 255; e8 = 0;   end
            2'd2: begin e16 = lb16 & 255;        e8 = lb8; end
            default: begin e16 = (lb16 >> 8) & 255; e8 = 0; end
        endcase
        chk("done", done, exp_done);
        chk("busy", busy, exp_busy);
        chk("count_a", count_a, la16);
        chk("count_b", count_b, lb16);
        chk("ovf_a", ovf_a, oa16);
        chk("ovf_b", ovf_b, ob16);
        chk("rd_byte", rd_byte, e16);
        chk("done8", done_s, exp_done);
        chk("busy8", busy_s, exp_busy);
        chk("count_a8", count_a_s, la8);
        chk("count_b8", count_b_s, lb8);
        chk("ovf_a8", ovf_a_s, oa8);
        chk("ovf_b8", ovf_b_s, ob8);
        chk("rd_byte8", rd_byte_s, e8);
    end

    // Oscillator pattern generators: 0 static, 1 periodic, 2 random
    int mode_a = 0, mode_b = 0;
    int per_a = 2, per_b = 2;
    int ph_a = 0, ph_b = 0;
    bit lvl_a = 0, lvl_b = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        ph_a = (ph_a + 1) % per_a;
        ph_b = (ph_b + 1) % per_b;
        case (mode_a)
            0: osc_a = lvl_a;
            1: osc_a = (ph_a < per_a / 2);
            default: osc_a = ($urandom_range(0, 1) == 1);
        endcase
        case (mode_b)
            0: osc_b = lvl_b;
            1: osc_b = (ph_b < per_b / 2);
            default: osc_b = ($urandom_range(0, 1) == 1);
        endcase
        rd_sel = 2'($urandom_range(0, 3));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input int gl);
        gate_len = GATE_W'(gl);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        gate_len = '0;
        osc_a = 1'b0;
        osc_b = 1'b0;
        rd_sel = 2'd0;
        run(4);
        rst_n = 1'b1;
        run(3);

        mode_a = 1; per_a = 4;
        mode_b = 1; per_b = 10;
        pulse(100);
        run(110);

        mode_a = 1; per_a = 2;
        pulse(1000);
        run(1010);
        mode_a = 0; lvl_a = 1'b0;
        pulse(50);
        run(60);

        mode_a = 0; lvl_a = 1'b1;
        pulse(0);
        run(8);
        pulse(1);
        run(8);

        mode_a = 1; per_a = 6;
        pulse(50);
        run(10);
        start = 1'b1;
        run(5);
        start = 1'b0;
        run(45);
        start = 1'b1;
        gate_len = GATE_W'(50);
        run(110);
        start = 1'b0;
        run(60);

        pulse(100);
        run(20);
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(110);

        for (int i = 0; i < 40; i++) begin
            mode_a = int'($urandom_range(0, 2));
            mode_b = int'($urandom_range(0, 2));
            per_a = int'($urandom_range(2, 12));
            per_b = int'($urandom_range(2, 12));
            lvl_a = ($urandom_range(0, 1) == 1);
            lvl_b = ($urandom_range(0, 1) == 1);
            gate_len = GATE_W'($urandom_range(0, 200));
            start = 1'b1;
            run(int'($urandom_range(1, 30)));
            start = 1'b0;
            run(int'($urandom_range(0, 250)));
        end
        run(260);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
